// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam int INSTR_BITS_DEF = 16;

    // Value returned for misaligned fetches and written by the clear sweep.
    localparam logic [INSTR_BITS_DEF-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction word store: one synchronous write port, one combinational read port.
// Contents are not reset; clearing is done by the responder's sweep.
module imem_array #(
    parameter int AW = 5,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Single write port, shared by the clear sweep and the program-load port.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: req/ready fetch handshake, held response until
// ack, program-load write port, optional power-on clear sweep.
// Optional feature macro: IMEM_CLEAR_EN (reset enters a sweep that zeroes the store).
module imem_responder
    import imem_pkg::*;
#(
    parameter int PC_BITS    = 6,
    parameter int INSTR_BITS = INSTR_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [PC_BITS-1:0]    fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [INSTR_BITS-1:0] fetch_instr,
    output logic                  fetch_misalign,
    input  logic                  fetch_ack,
    input  logic                  prog_we,
    input  logic [PC_BITS-2:0]    prog_addr,
    input  logic [INSTR_BITS-1:0] prog_data,
    output logic                  busy
);

    localparam int WA = PC_BITS - 1;
    localparam logic [INSTR_BITS-1:0] NOP = INSTR_BITS'(NOP_WORD);

    imem_state_e           state_q, state_d;
    logic                  fetch_accept;
    logic                  mem_we;
    logic [WA-1:0]         mem_waddr;
    logic [INSTR_BITS-1:0] mem_wdata;
    logic [INSTR_BITS-1:0] mem_rdata;

`ifdef IMEM_CLEAR_EN
    localparam int WORDS = 1 << WA;
    localparam imem_state_e RST_STATE = CLEAR;
    logic [WA-1:0] clr_cnt;
    logic          sweep;

    assign sweep = (state_q == CLEAR);

    // Clear counter: walks word 0..last while sweeping, restarts on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            clr_cnt <= '0;
        else if (sweep)
            clr_cnt <= clr_cnt + 1'b1;
    end

    // Sweep owns the write port; loads only land outside CLEAR.
    always_comb begin
        mem_we    = sweep | prog_we;
        mem_waddr = sweep ? clr_cnt : prog_addr;
        mem_wdata = sweep ? NOP : prog_data;
    end

    assign busy = sweep;
`else
    localparam imem_state_e RST_STATE = IDLE;

    // No sweep: the load port owns the write port outright.
    always_comb begin
        mem_we    = prog_we;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;
    end

    assign busy = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= RST_STATE;
        else
            state_q <= state_d;
    end

    // Next-state and handshake decode; a load write outranks a fetch in IDLE.
    always_comb begin
        state_d     = state_q;
        fetch_ready = 1'b0;
        case (state_q)
`ifdef IMEM_CLEAR_EN
            CLEAR: begin
                if (clr_cnt == WA'(WORDS - 1))
                    state_d = IDLE;
            end
`endif
            IDLE: begin
                fetch_ready = !prog_we;
                if (!prog_we && fetch_req)
                    state_d = RESP;
            end
            RESP: begin
                if (fetch_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fetch_accept = fetch_ready && fetch_req;
    assign fetch_valid  = (state_q == RESP);

    // Response registers: captured once on accept, then held through RESP so a
    // load into the same word cannot disturb a response already in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_instr    <= '0;
            fetch_misalign <= 1'b0;
        end else if (fetch_accept) begin
            fetch_instr    <= fetch_addr[0] ? NOP : mem_rdata;
            fetch_misalign <= fetch_addr[0];
        end
    end

    imem_array #(
        .AW (WA),
        .DW (INSTR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (fetch_addr[PC_BITS-1:1]),
        .rdata (mem_rdata)
    );

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the word-addressed instruction store: the serving end of the PC-driven fetch interface. It accepts a byte fetch address from the PC side under a req/ready handshake, reads one 16-bit instruction word, and holds the response until the consumer acknowledges it. A separate program-load port writes words into the store. It sits between the PC/FSM and the decode stage.

## Interface
- PC_BITS, 6, byte-address width; store holds 2^(PC_BITS-1) words (32 by default)
- INSTR_BITS, 16, instruction word width
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch request; sampled only while fetch_ready=1
- fetch_addr  in  PC_BITS  byte address of the requested instruction
- fetch_ready  out  1  responder can accept a request this cycle
- fetch_valid  out  1  response word available
- fetch_instr  out  INSTR_BITS  instruction word; stable while fetch_valid=1
- fetch_misalign  out  1  response belongs to an odd byte address
- fetch_ack  in  1  consumer accepts the response; meaningful only while fetch_valid=1
- prog_we  in  1  program-load write strobe
- prog_addr  in  PC_BITS-1  word index for the load write
- prog_data  in  INSTR_BITS  word to write
- busy  out  1  clear sweep in progress; loads and fetches are not accepted

## Operation
- FSM states: CLEAR, IDLE, RESP.
- CLEAR: busy=1, fetch_ready=0. A counter writes zero to word 0, 1, …, last, one word per cycle. Leave to IDLE on the edge that writes the last word. prog_we and fetch_req are ignored.
- IDLE: fetch_ready = !prog_we, so a load write has priority over a fetch in the same cycle. When fetch_ready and fetch_req are both 1, capture the response and go to RESP.
- Response capture for an even fetch_addr: fetch_instr = word[fetch_addr[PC_BITS-1:1]], fetch_misalign=0.
- Response capture for an odd fetch_addr: fetch_instr=0, fetch_misalign=1.
- RESP: fetch_valid=1, fetch_ready=0, and fetch_instr and fetch_misalign are held. When fetch_ack=1, go to IDLE and clear fetch_valid.
- Load writes: accepted in IDLE and RESP when prog_we=1, writing prog_data to word[prog_addr].
  - A write during RESP does not change the held fetch_instr, even when it targets the same word.
- Address wrap: none is needed; every PC_BITS value maps to a legal word index.
- Reset, including in the middle of a fetch or a sweep:
  - state goes to CLEAR, or to IDLE when the sweep is compiled out (see Configuration)
  - fetch_valid=0, fetch_instr=0, fetch_misalign=0, clear counter=0
  - busy=1 with the sweep compiled in, 0 without
  - a pending response is discarded

## Timing
- Fetch latency: request accepted at edge N, so fetch_valid=1 from edge N to ack. Minimum throughput is one fetch per 2 cycles; ack and a new request never overlap.
- If fetch_ack is already 1 in the first RESP cycle, fetch_valid lasts exactly 1 cycle and fetch_ready returns after the next edge.
- A load write takes effect at its edge; a fetch accepted at the next edge sees the new data.
- Clear sweep: word k is zeroed at rising edge k+1 after reset deasserts. busy falls and fetch_ready may rise after edge 2^(PC_BITS-1) (32 by default).
- fetch_ready, busy and fetch_valid are decoded from state, except that fetch_ready is also gated combinationally by prog_we.

## Configuration
- IMEM_CLEAR_EN defined: reset enters CLEAR and the store is zeroed as above.
- IMEM_CLEAR_EN undefined:
  - there is no CLEAR state or counter, and busy is tied to 0
  - reset enters IDLE, and fetch_ready is 1 in the first cycle after reset (subject to prog_we)
  - store contents survive reset; contents after power-up are undefined

## Structure
- imem_pkg contains:
  - state enum (CLEAR, IDLE, RESP)
  - INSTR_BITS default
  - NOP_WORD = 0, used for the misaligned and cleared value
- Sub-module imem_array holds the word storage, with:
  - one write port, muxed between the sweep and prog_*
  - one combinational read port indexed by fetch_addr[PC_BITS-1:1]
- imem_responder contains the FSM, the clear counter, the response registers and the handshake.

## Test plan
- Reset sweep (IMEM_CLEAR_EN): release reset, then count edges → busy=1 for 32 edges, fetch_ready=1 after edge 32; a fetch of addr 0x3E returns 0x0000.
- Load then fetch: write 0xA5C3 to word 5; fetch addr 0x0A → fetch_valid the next cycle with 0xA5C3 and misalign=0; hold ack low for 3 cycles → fetch_valid and data stay stable.
- Misaligned: fetch addr 0x0B → fetch_instr=0x0000, fetch_misalign=1; ack → back to IDLE, fetch_ready=1 the following cycle.
- Collision: in IDLE, drive prog_we=1 to word 2 (0x1234) and fetch_req at addr 0x04 in the same cycle → fetch_ready=0 and the write lands. Next cycle fetch → 0x1234. Then, while in RESP, write 0xFFFF to word 2 → held fetch_instr stays 0x1234.
- Reset mid-RESP: assert reset asynchronously while fetch_valid=1 → fetch_valid and fetch_instr drop to 0 immediately; sweep restarts.
- IMEM_CLEAR_EN undefined: write word 1 = 0xBEEF, pulse reset → fetch_ready=1 in the first cycle after reset; fetch of addr 0x02 returns 0xBEEF.
